// File: rtl/nibble_serial_adder_ctrl.sv
// Purpose: WIDTH-bit adder built by sequencing one 4-bit ripple-carry cell, one nibble per cycle, LSB first.
// Latency: busy for WIDTH/4 cycles after the start-accept edge, then a one-cycle done pulse with the registered result.
// Backpressure: none; start is accepted only in IDLE or DONE, and is ignored (not queued) while busy.
// Optional build macro SIGNED_OVF_EN adds the ovf output (two's-complement overflow of the final result).

// Combinational 4-bit ripple-carry adder cell.
// Latency: zero cycles (pure combinational).
// Backpressure: not applicable.
module RippleCarryAdder_4bit (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]     = in1[i] ^ in2[i] ^ carry[i];
        assign carry[i+1] = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
    end

    assign c_out = carry[4];
endmodule

// Multi-cycle wide adder controller reusing a single 4-bit cell.
// Latency: NIBBLES RUN cycles, done asserted in the cycle after edge E0+NIBBLES.
// Backpressure: start ignored during RUN; accepted in DONE for back-to-back operation.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               accept;
    logic               last;
    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [3:0]         cell_sum;
    logic               cell_cout;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the busy/done strobes and datapath controls.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Select the current nibble of each latched operand for the shared cell.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    RippleCarryAdder_4bit u_cell (
        .in1   (nib_a),
        .in2   (nib_b),
        .c_in  (carry_q),
        .sum   (cell_sum),
        .c_out (cell_cout)
    );

`ifdef SIGNED_OVF_EN
    // Carry into the MSB of the cell, recovered from the MSB sum bit.
    logic msb_carry;
    assign msb_carry = nib_a[3] ^ nib_b[3] ^ cell_sum[3];
`endif

    // Operand latch on accept, then one nibble of result per RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= in1;
            b_q     <= in2;
            carry_q <= c_in;
            idx_q   <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (busy) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    sum[4*i +: 4] <= cell_sum;
                end
            end
            carry_q <= cell_cout;
            idx_q   <= idx_q + 1'b1;
            if (last) begin
                c_out <= cell_cout;
`ifdef SIGNED_OVF_EN
                ovf   <= msb_carry ^ cell_cout;
`endif
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (WIDTH=16): directed and random adds against an arithmetic reference.
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with SIGNED_OVF_EN defined to also check the ovf output.
module tb_nibble_serial_adder_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SIGNED_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: unsigned {c_out,sum} and signed overflow from plain integer arithmetic.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        longint t;
        t = longint'(a) + longint'(b) + longint'(ci);
        return t[W:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        longint t;
        t = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        return (t > 32767) || (t < -32768);
    endfunction

    function automatic logic get_ovf();
`ifdef SIGNED_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Starts an add at the current falling edge and follows it until done (or a cycle budget runs out).
    // Operand inputs are scrambled every cycle after acceptance; start is re-pulsed at sample restart_at if nonzero.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int restart_at,
                         output logic [W-1:0] s, output logic co, output logic ov,
                         output int lat, output int bcnt, output logic busy_at_done);
        int k;
        logic seen;
        in1   = a;
        in2   = b;
        c_in  = ci;
        start = 1'b1;
        k     = 0;
        bcnt  = 0;
        seen  = 1'b0;
        busy_at_done = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (busy) bcnt++;
            seen = done;
            busy_at_done = busy;
            start = (k == restart_at);
            in1   = W'($urandom);
            in2   = W'($urandom);
            c_in  = 1'($urandom);
        end
        start = 1'b0;
        lat = k;
        s   = sum;
        co  = c_out;
        ov  = get_ovf();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        c_in  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, sum, c_out, get_ovf()} !== '0) begin
            n_err++;
            $display("FAIL reset_values: got busy=%b done=%b sum=%h c_out=%b ovf=%b, want all 0", busy, done, sum, c_out, get_ovf());
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, sum, c_out} !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b done=%b sum=%h c_out=%b, want all 0", busy, done, sum, c_out);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
        logic [W-1:0] tb [6] = '{16'h0FFF, 16'h0001, 16'hFFFF, 16'h0001, 16'h8000, 16'h0000};
        logic         tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] s;
        logic co, ov, bad;
        logic [W:0] exp;
        int lat, bcnt;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], tc[i], 0, s, co, ov, lat, bcnt, bad);
            exp = ref_sum(ta[i], tb[i], tc[i]);
            n_cmp++;
            if (lat !== NIB + 1 || bcnt !== NIB || bad !== 1'b0) begin
                n_err++;
                $display("FAIL directed_timing[%0d]: got done_at=%0d busy_cycles=%0d busy_with_done=%b, want %0d/%0d/0", i, lat, bcnt, bad, NIB + 1, NIB);
            end
            n_cmp++;
            if ({co, s} !== exp) begin
                n_err++;
                $display("FAIL directed_sum[%0d]: %h+%h+%b got c_out=%b sum=%h, want %b/%h", i, ta[i], tb[i], tc[i], co, s, exp[W], exp[W-1:0]);
            end
`ifdef SIGNED_OVF_EN
            n_cmp++;
            if (ov !== ref_ovf(ta[i], tb[i], tc[i])) begin
                n_err++;
                $display("FAIL directed_ovf[%0d]: got %b want %b", i, ov, ref_ovf(ta[i], tb[i], tc[i]));
            end
`endif
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || {c_out, sum} !== exp) begin
                n_err++;
                $display("FAIL directed_hold[%0d]: got done=%b c_out=%b sum=%h, want 0/%b/%h", i, done, c_out, sum, exp[W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s;
        logic ci, co, ov, bad;
        logic [W:0] exp;
        int lat, bcnt;
        for (int i = 0; i < 40; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            ci = 1'($urandom);
            do_op(a, b, ci, 0, s, co, ov, lat, bcnt, bad);
            exp = ref_sum(a, b, ci);
            n_cmp++;
            if (lat !== NIB + 1 || {co, s} !== exp || ov !== (get_ovf() & ref_ovf(a, b, ci) | (ov & ~get_ovf()))) begin
                n_err++;
                $display("FAIL random[%0d]: %h+%h+%b got done_at=%0d c_out=%b sum=%h, want %0d/%b/%h", i, a, b, ci, lat, co, s, NIB + 1, exp[W], exp[W-1:0]);
            end
`ifdef SIGNED_OVF_EN
            n_cmp++;
            if (ov !== ref_ovf(a, b, ci)) begin
                n_err++;
                $display("FAIL random_ovf[%0d]: got %b want %b", i, ov, ref_ovf(a, b, ci));
            end
`endif
            // Alternate between back-to-back starts and idle gaps.
            if (i % 2 == 1) repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] s;
        logic co, ov, bad;
        int lat, bcnt;
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, s, co, ov, lat, bcnt, bad);
        n_cmp++;
        if ({co, s} !== 17'h1FFFF) begin
            n_err++;
            $display("FAIL b2b_first: got c_out=%b sum=%h, want 1/ffff", co, s);
        end
        // start is driven during the DONE cycle itself.
        do_op(16'h0001, 16'h0001, 1'b0, 0, s, co, ov, lat, bcnt, bad);
        n_cmp++;
        if (lat !== NIB + 1 || bcnt !== NIB) begin
            n_err++;
            $display("FAIL b2b_latency: got done_at=%0d busy_cycles=%0d, want %0d/%0d", lat, bcnt, NIB + 1, NIB);
        end
        n_cmp++;
        if ({co, s} !== 17'h00002) begin
            n_err++;
            $display("FAIL b2b_second: got c_out=%b sum=%h, want 0/0002", co, s);
        end
        @(negedge clk);
    endtask

    task automatic test_start_during_run();
        logic [W-1:0] s;
        logic co, ov, bad;
        int lat, bcnt, extra;
        do_op(16'h4321, 16'h1111, 1'b1, 2, s, co, ov, lat, bcnt, bad);
        n_cmp++;
        if (lat !== NIB + 1 || {co, s} !== 17'h05433) begin
            n_err++;
            $display("FAIL ignore_start_result: got done_at=%0d c_out=%b sum=%h, want %0d/0/5433", lat, co, s, NIB + 1);
        end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL ignore_start_queued: got %0d busy/done cycles after done, want 0", extra);
        end
        n_cmp++;
        if ({c_out, sum} !== 17'h05433) begin
            n_err++;
            $display("FAIL ignore_start_hold: got c_out=%b sum=%h, want 0/5433", c_out, sum);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s;
        logic co, ov, bad;
        int lat, bcnt, extra;
        in1   = 16'h1234;
        in2   = 16'h0FFF;
        c_in  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || sum !== 16'h0003) begin
            n_err++;
            $display("FAIL midrun_partial: got busy=%b sum=%h, want 1/0003", busy, sum);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, sum, c_out, get_ovf()} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h c_out=%b, want all 0", busy, done, sum, c_out);
        end
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL midrun_no_done: got %0d busy/done cycles after reset, want 0", extra);
        end
        do_op(16'hA5A5, 16'h5A5A, 1'b1, 0, s, co, ov, lat, bcnt, bad);
        n_cmp++;
        if (lat !== NIB + 1 || {co, s} !== 17'h10000) begin
            n_err++;
            $display("FAIL after_reset_op: got done_at=%0d c_out=%b sum=%h, want %0d/1/0000", lat, co, s, NIB + 1);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_during_run();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
